// File: rtl/ccg_seq_bench_pkg.sv
// Shared definitions for the pipelined CCG benchmark: term indexing and stage sizing.
// Latency: n/a (compile-time helpers only).
// Backpressure: n/a.
// Contents: parameter limits, idx() term pairing, per-stage fan-in and term counts.
package ccg_pkg;

   localparam int N_IN_MIN   = 3;
   localparam int N_GRP_MIN  = 1;
   localparam int STAGES_MIN = 1;
   localparam int STAGES_MAX = 4;

   // Partner bit of x[i] in the AND term of group g.
   function automatic int idx(input int i, input int g, input int n_in);
      return (i + g + 1) % n_in;
   endfunction

   // Fan-in used by every reduction stage: the smallest f with
   // f**(stages-1) >= n_in, so the reduction stages finish at one term.
   function automatic int red_fan(input int n_in, input int stages);
      int  f;
      int  p;
      bit  found;
      f     = n_in;
      found = 1'b0;
      if (stages > 1) begin
         for (int c = 2; c <= n_in; c++) begin
            if (!found) begin
               p = 1;
               for (int k = 0; k < stages - 1; k++) p = p * c;
               if (p >= n_in) begin
                  f     = c;
                  found = 1'b1;
               end
            end
         end
      end
      return f;
   endfunction

   // Fan-in of stage s (1-based). Stage 1 only registers the AND terms,
   // unless it is the sole stage, in which case it reduces everything.
   function automatic int stage_fan(input int n_in, input int stages, input int s);
      if (stages == 1) return n_in;
      if (s == 1)      return 1;
      return red_fan(n_in, stages);
   endfunction

   // Terms per group held after stage s; s = 0 means the raw AND terms.
   function automatic int stage_cnt(input int n_in, input int stages, input int s);
      int c;
      int f;
      if (stages == 1) return (s == 0) ? n_in : 1;
      c = n_in;
      f = red_fan(n_in, stages);
      for (int k = 2; k <= s; k++) c = (c + f - 1) / f;
      return c;
   endfunction

endpackage

// File: rtl/ccg_seq_bench_if.sv
// Valid/ready bus between stimulus source, CCG benchmark and result sink.
// Latency: n/a (wires only).
// Backpressure: out_ready from the sink, in_ready back to the source.
// Modports: master = source/sink side, slave = the benchmark block.
interface ccg_seq_bench_if #(
   parameter int N_IN  = 20,
   parameter int N_OUT = 10
);
   logic [N_IN-1:0]  in_data;
   logic             in_valid;
   logic             in_ready;
   logic             acc_clr;
   logic [N_OUT-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_data, in_valid, acc_clr, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_data, in_valid, acc_clr, out_ready,
      output in_ready, out_data, out_valid
   );
endinterface

// File: rtl/ccg_seq_bench_pipe_stage.sv
// One pipeline stage: XOR-reduces groups of FAN adjacent terms and registers them with a valid bit.
// Latency: 1 cycle.
// Backpressure: holds valid and data unchanged while adv is low.
// Ports: clk, rst_n, adv (shift enable), in_vld/in_dat (N_GRP*W_IN), out_vld/out_dat (N_GRP*W_OUT).
module ccg_pipe_stage #(
   parameter int N_GRP = 2,
   parameter int W_IN  = 20,
   parameter int W_OUT = 1,
   parameter int FAN   = 20
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   adv,
   input  logic                   in_vld,
   input  logic [N_GRP*W_IN-1:0]  in_dat,
   output logic                   out_vld,
   output logic [N_GRP*W_OUT-1:0] out_dat
);

   logic [N_GRP*W_OUT-1:0] red;

   // Output term j of a group folds input terms [j*FAN, j*FAN+FAN-1],
   // clipped at the group's last term.
   for (genvar g = 0; g < N_GRP; g++) begin : gen_grp
      for (genvar j = 0; j < W_OUT; j++) begin : gen_term
         localparam int LO = g * W_IN + j * FAN;
         localparam int HI = g * W_IN + ((j * FAN + FAN < W_IN) ? (j * FAN + FAN) : W_IN) - 1;
         assign red[g*W_OUT + j] = ^in_dat[HI:LO];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (adv) begin
         out_vld <= in_vld;
         out_dat <= red;
      end
   end

endmodule

// File: rtl/ccg_seq_bench.sv
// Pipelined CCG benchmark: N_GRP quadratic parity functions of x, each replicated DUP times.
// Latency: STAGES cycles from input handshake to out_valid, one vector per cycle.
// Backpressure: whole pipe stalls while out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Ports: clk, rst_n (async, active low), bus (slave: in_data/in_valid/in_ready, acc_clr,
// out_data/out_valid/out_ready). Optional macro CCG_ACC_EN adds a per-group XOR accumulator.
module ccg_seq_bench
   import ccg_pkg::*;
#(
   parameter int N_IN   = 20,
   parameter int N_GRP  = 2,
   parameter int DUP    = 5,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   ccg_seq_bench_if.slave     bus
);

   if (N_IN < N_IN_MIN) begin : gen_chk_n_in
      $error("ccg_seq_bench: N_IN below minimum");
   end
   if (N_GRP < N_GRP_MIN || N_GRP > N_IN - 1) begin : gen_chk_n_grp
      $error("ccg_seq_bench: N_GRP out of range");
   end
   if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : gen_chk_stages
      $error("ccg_seq_bench: STAGES out of range");
   end

   logic                  adv;
   logic [N_GRP*N_IN-1:0] terms;
   logic [N_GRP-1:0]      y;
   logic                  y_vld;
   logic [N_GRP-1:0]      r;

   // AND terms x[i] & x[(i+g+1) mod N_IN], N_IN per group, group-major.
   for (genvar g = 0; g < N_GRP; g++) begin : gen_and_grp
      for (genvar i = 0; i < N_IN; i++) begin : gen_and_bit
         assign terms[g*N_IN + i] = bus.in_data[i] & bus.in_data[idx(i, g, N_IN)];
      end
   end

   // Stage s narrows the terms per group from stage_cnt(s-1) to stage_cnt(s);
   // the last stage always ends at a single bit per group.
   for (genvar s = 1; s <= STAGES; s++) begin : gen_stg
      localparam int W_IN  = stage_cnt(N_IN, STAGES, s - 1);
      localparam int W_OUT = stage_cnt(N_IN, STAGES, s);
      localparam int FAN   = stage_fan(N_IN, STAGES, s);

      logic                   src_vld;
      logic [N_GRP*W_IN-1:0]  src_dat;
      logic                   vld;
      logic [N_GRP*W_OUT-1:0] dat;

      if (s == 1) begin : gen_src_in
         assign src_vld = bus.in_valid;
         assign src_dat = terms;
      end else begin : gen_src_prev
         assign src_vld = gen_stg[s-1].vld;
         assign src_dat = gen_stg[s-1].dat;
      end

      ccg_pipe_stage #(
         .N_GRP (N_GRP),
         .W_IN  (W_IN),
         .W_OUT (W_OUT),
         .FAN   (FAN)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .adv     (adv),
         .in_vld  (src_vld),
         .in_dat  (src_dat),
         .out_vld (vld),
         .out_dat (dat)
      );
   end

   assign y     = gen_stg[STAGES].dat;
   assign y_vld = gen_stg[STAGES].vld;

   // Bubbles are not collapsed: any stall freezes every stage.
   assign adv          = !y_vld || bus.out_ready;
   assign bus.in_ready = adv;
   assign bus.out_valid = y_vld;

`ifdef CCG_ACC_EN
   logic [N_GRP-1:0] acc;

   // A clear in the same cycle as an output handshake wins; the output
   // on the bus during that cycle still shows the pre-clear value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (bus.acc_clr) begin
         acc <= '0;
      end else if (y_vld && bus.out_ready) begin
         acc <= acc ^ y;
      end
   end

   assign r = y ^ acc;
`else
   logic unused_acc_clr;
   assign unused_acc_clr = bus.acc_clr;
   assign r = y;
`endif

   for (genvar g = 0; g < N_GRP; g++) begin : gen_rep
      assign bus.out_data[g*DUP +: DUP] = {DUP{r[g]}};
   end

endmodule

// File: tb/tb_ccg_seq_bench.sv
// Bench for ccg_seq_bench: three instances (default, STAGES=1, STAGES=4) share one stimulus.
// A queue-with-countdown model predicts in_ready/out_valid/out_data for each instance every cycle.
// Directed literal cases pin the model and the latencies; a random phase streams 1000 vectors.
module tb_ccg_seq_bench;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [19:0] in_data;
   logic        in_valid;
   logic        out_ready;
   logic        acc_clr;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ccg_seq_bench_if #(.N_IN(20), .N_OUT(10)) b0 ();
   ccg_seq_bench_if #(.N_IN(20), .N_OUT(3))  b1 ();
   ccg_seq_bench_if #(.N_IN(20), .N_OUT(3))  b2 ();

   assign b0.in_data = in_data;   assign b0.in_valid = in_valid;
   assign b0.out_ready = out_ready; assign b0.acc_clr = acc_clr;
   assign b1.in_data = in_data;   assign b1.in_valid = in_valid;
   assign b1.out_ready = out_ready; assign b1.acc_clr = acc_clr;
   assign b2.in_data = in_data;   assign b2.in_valid = in_valid;
   assign b2.out_ready = out_ready; assign b2.acc_clr = acc_clr;

   ccg_seq_bench #(.N_IN(20), .N_GRP(2), .DUP(5), .STAGES(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   ccg_seq_bench #(.N_IN(20), .N_GRP(3), .DUP(1), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   ccg_seq_bench #(.N_IN(20), .N_GRP(3), .DUP(1), .STAGES(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

   logic [15:0] od [3];
   logic        ov [3];
   logic        ir [3];

   assign od[0] = {6'b0, b0.out_data};
   assign od[1] = {13'b0, b1.out_data};
   assign od[2] = {13'b0, b2.out_data};
   assign ov[0] = b0.out_valid;  assign ov[1] = b1.out_valid;  assign ov[2] = b2.out_valid;
   assign ir[0] = b0.in_ready;   assign ir[1] = b1.in_ready;   assign ir[2] = b2.in_ready;

   function automatic int stg_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
   endfunction
   function automatic int ng_of(input int k);
      return (k == 0) ? 2 : 3;
   endfunction
   function automatic int dp_of(input int k);
      return (k == 0) ? 5 : 1;
   endfunction

   // Reference: y_g = XOR_i x[i] & x[(i+g+1) mod 20].
   function automatic logic [3:0] yfun(input logic [19:0] x, input int ng);
      logic [3:0] y;
      y = '0;
      for (int g = 0; g < ng; g++)
         for (int i = 0; i < 20; i++)
            y[g] = y[g] ^ (x[i] & x[(i + g + 1) % 20]);
      return y;
   endfunction

   function automatic logic [15:0] rep(input logic [3:0] y, input int ng, input int dp);
      logic [15:0] o;
      o = '0;
      for (int g = 0; g < ng; g++)
         for (int kk = 0; kk < dp; kk++)
            o[g*dp + kk] = y[g];
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model + per-cycle compare ----------------
   // Each instance: ordered list of in-flight vectors with the number of
   // advancing edges still needed before the vector reaches the output.
   logic [19:0] mx   [3][8];
   int          mrem [3][8];
   int          mn   [3];
   logic [3:0]  macc [3];
   logic        hold   [3];
   logic [15:0] hold_d [3];

   initial begin
      logic       e_ov;
      logic       e_ir;
      logic [3:0] hy;
      for (int k = 0; k < 3; k++) begin
         mn[k] = 0; macc[k] = '0; hold[k] = 1'b0; hold_d[k] = '0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
               mn[k] = 0; macc[k] = '0; hold[k] = 1'b0;
            end
            e_ov = (mn[k] > 0) && (mrem[k][0] == 0);
            e_ir = !e_ov || out_ready;
            chk($sformatf("u%0d.out_valid", k), {31'b0, ov[k]}, {31'b0, e_ov});
            chk($sformatf("u%0d.in_ready", k), {31'b0, ir[k]}, {31'b0, e_ir});
            if (e_ov) begin
               hy = yfun(mx[k][0], ng_of(k)) ^ macc[k];
               chk($sformatf("u%0d.out_data", k), {16'b0, od[k]}, {16'b0, rep(hy, ng_of(k), dp_of(k))});
            end
            if (hold[k] && rst_n)
               chk($sformatf("u%0d.stall_stable", k), {16'b0, od[k]}, {16'b0, hold_d[k]});
            hold[k]   = rst_n && ov[k] && !out_ready;
            hold_d[k] = od[k];
            if (rst_n) begin
               if (e_ir) begin
                  if (e_ov && out_ready) begin
`ifdef CCG_ACC_EN
                     if (!acc_clr) macc[k] = macc[k] ^ yfun(mx[k][0], ng_of(k));
`endif
                     for (int j = 0; j < mn[k] - 1; j++) begin
                        mx[k][j]   = mx[k][j+1];
                        mrem[k][j] = mrem[k][j+1];
                     end
                     mn[k]--;
                  end
                  for (int j = 0; j < mn[k]; j++)
                     if (mrem[k][j] > 0) mrem[k][j]--;
                  if (in_valid) begin
                     mx[k][mn[k]]   = in_data;
                     mrem[k][mn[k]] = stg_of(k) - 1;
                     mn[k]++;
                  end
               end
`ifdef CCG_ACC_EN
               if (acc_clr) macc[k] = '0;
`endif
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0; acc_clr = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // One isolated vector; checks per-instance latency, single-cycle valid and data.
   task automatic send_one(input logic [19:0] x, input logic [15:0] e0, input logic [15:0] e12);
      int lat [3];
      int cnt [3];
      for (int k = 0; k < 3; k++) begin lat[k] = 0; cnt[k] = 0; end
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = x; out_ready = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (c == 1) in_valid = 1'b0;
         for (int k = 0; k < 3; k++) begin
            if (ov[k]) begin
               cnt[k]++;
               if (lat[k] == 0) lat[k] = c;
               chk($sformatf("lit_u%0d_data_%05h", k, x), {16'b0, od[k]}, {16'b0, (k == 0) ? e0 : e12});
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("lit_u%0d_latency", k), lat[k], stg_of(k));
         chk($sformatf("lit_u%0d_valid_cycles", k), cnt[k], 1);
      end
   endtask

   initial begin
      int   sent;
      int   got;
      int   cyc;
      int   stale;
      logic took;
      logic gave;

      rst_n = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; acc_clr = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset_u%0d_out_valid", k), {31'b0, ov[k]}, 32'd0);
         chk($sformatf("reset_u%0d_out_data", k), {16'b0, od[k]}, 32'd0);
         chk($sformatf("reset_u%0d_in_ready", k), {31'b0, ir[k]}, 32'd1);
      end

      // Pin the reference functions with hand-computed values.
      chk("model_y_00003", {16'b0, rep(yfun(20'h00003, 2), 2, 5)}, 32'h01F);
      chk("model_y_00007", {16'b0, rep(yfun(20'h00007, 2), 2, 5)}, 32'h3E0);
      chk("model_y_FFFFF", {16'b0, rep(yfun(20'hFFFFF, 2), 2, 5)}, 32'h000);
      chk("model_g3_00007", {28'b0, yfun(20'h00007, 3)}, 32'h2);

      do_reset(); send_one(20'h00003, 16'h01F, 16'h1);
      do_reset(); send_one(20'h00007, 16'h3E0, 16'h2);
      do_reset(); send_one(20'hFFFFF, 16'h000, 16'h0);

`ifdef CCG_ACC_EN
      do_reset();
      send_one(20'h00003, 16'h01F, 16'h1);
      send_one(20'h00003, 16'h000, 16'h0);
      send_one(20'h00007, 16'h3E0, 16'h2);
      @(posedge clk); #1 acc_clr = 1'b1;
      @(posedge clk); #1 acc_clr = 1'b0;
      send_one(20'h00007, 16'h3E0, 16'h2);
`endif

      // Back-to-back stream of 8 with out_ready pattern 1,0,0,1,...
      do_reset();
      sent = 0; got = 0; cyc = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 20'($urandom); out_ready = 1'b1;
      while ((sent < 8 || got < 8) && cyc < 200) begin
         @(negedge clk);
         took = in_valid && ir[0];
         gave = ov[0] && out_ready;
         @(posedge clk); #1;
         cyc++;
         if (took) sent++;
         if (gave) got++;
         if (took) begin
            if (sent < 8) in_data = 20'($urandom);
            else          in_valid = 1'b0;
         end
         out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end
      chk("stall_sent", sent, 8);
      chk("stall_got", got, 8);

      // Reset with vectors in flight.
      do_reset();
      out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b1; in_data = 20'h00003;
      @(posedge clk); #1 in_data = 20'h00007;
      @(posedge clk); #1 rst_n = 1'b0; in_valid = 1'b0;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("midrst_u%0d_out_valid", k), {31'b0, ov[k]}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stale = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) if (ov[k]) stale++;
      end
      chk("midrst_stale_outputs", stale, 0);

      // Random stream of 1000 vectors with random backpressure and clears.
      do_reset();
      sent = 0; cyc = 0;
      while (sent < 1000 && cyc < 6000) begin
         @(negedge clk);
         took = in_valid && ir[0];
         @(posedge clk); #1;
         cyc++;
         if (took) sent++;
         if (took || !in_valid) begin
            in_valid = ($urandom_range(0, 9) < 8);
            in_data  = 20'($urandom);
         end
         out_ready = ($urandom_range(0, 9) < 7);
         acc_clr   = ($urandom_range(0, 15) == 0);
      end
      chk("rand_sent", sent, 1000);

      in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
